// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared constants for the bit-serial subtractor and the
//                display path that consumes its result.
//                  DEFAULT_WIDTH - default operand/result width
//                  S_IDLE/S_SHIFT/S_DONE - controller state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sub1b_estruc.sv
`default_nettype none
// ============================================================================
//  Module      : sub1b_estruc
//  Description : Gate-level 1-bit full subtractor (A - B - Bi).
//                  A, B  - operand bits
//                  Bi    - borrow in
//                  D     - difference bit, A ^ B ^ Bi
//                  Bout  - borrow out, (~A & B) | (~(A ^ B) & Bi)
//  Revision    : 1.0 - initial release
// ============================================================================
module sub1b_estruc (
    input  logic A,
    input  logic B,
    input  logic Bi,
    output wire  D,
    output wire  Bout
);

    wire w_a_xor_b;
    wire w_not_a;
    wire w_not_axb;
    wire w_gen;
    wire w_prop;

    xor u_x0 (w_a_xor_b, A, B);
    xor u_x1 (D, w_a_xor_b, Bi);

    // Borrow is generated when A=0,B=1, and propagated when A==B.
    not u_n0 (w_not_a, A);
    and u_a0 (w_gen, w_not_a, B);
    not u_n1 (w_not_axb, w_a_xor_b);
    and u_a1 (w_prop, w_not_axb, Bi);
    or  u_o0 (Bout, w_gen, w_prop);

endmodule
`default_nettype wire

// File: rtl/sub_serial_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial_fsm
//  Description : Bit-serial unsigned subtractor D = A - B, LSB first, one
//                bit per clock through a single 1-bit full-subtractor cell.
//                  clk    - rising-edge clock
//                  rst_n  - asynchronous active-low reset
//                  start  - request, accepted only in IDLE
//                  A, B   - minuend / subtrahend, captured on accepted start
//                  busy   - high while the operation is being shifted
//                  done   - one-cycle pulse, D and Bout valid
//                  D      - (A - B) mod 2^WIDTH, held until next result
//                  Bout   - final borrow, 1 iff A < B
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_serial_fsm
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    // One extra bit so the count never wraps within an operation.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    logic               w_last;
    logic               w_cell_d;
    wire                w_cell_d_net;
    wire                w_cell_bout;

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_cell_d = w_cell_d_net;

    sub1b_estruc u_cell (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Bi   (r_borrow),
        .D    (w_cell_d_net),
        .Bout (w_cell_bout)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:              w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. busy/done are registered copies of
    // the state, so they lag the state by one edge and never see start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_busy <= (r_state == S_SHIFT);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= A;
                        r_b_sr   <= B;
                        r_res_sr <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0
                    // after WIDTH shifts.
                    r_res_sr <= {w_cell_d, r_res_sr[WIDTH-1:1]};
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_cell_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_d    <= r_res_sr;
                    r_bout <= r_borrow;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign Bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_sub_serial_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_serial_fsm
//  Description : Self-checking bench for sub_serial_fsm (WIDTH=4 and 8)
//                and the standalone sub1b_estruc cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_serial_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start4, busy4, done4, bout4;
    logic [3:0] a4, b4, d4;

    logic       start8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;

    logic       c_a, c_b, c_bi;
    wire        c_d, c_bo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] held_d  [2];
    logic       held_bo [2];

    sub_serial_fsm #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
    );

    sub_serial_fsm #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
    );

    sub1b_estruc u_cell (
        .A(c_a), .B(c_b), .Bi(c_bi), .D(c_d), .Bout(c_bo)
    );

    typedef struct {
        logic a, b, bi, d, bo;
    } cell_vec_t;

    typedef struct {
        int a, b, d, bo;
    } op_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? busy8 : busy4;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? done8 : done4;
    endfunction
    function automatic logic [7:0] get_d(input bit sel);
        return sel ? d8 : {4'h0, d4};
    endfunction
    function automatic logic get_bo(input bit sel);
        return sel ? bout8 : bout4;
    endfunction

    // One full operation with cycle-accurate handshake checks.
    task automatic run_op(input bit sel, input int a, input int b,
                          input int exp_d, input int exp_bo, input string tag);
        int w;
        w = sel ? 8 : 4;
        if (sel) begin start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); end
        else     begin start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); end
        tick();  // start accepted here
        if (sel) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
        else     begin start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); end
        for (int k = 1; k <= w; k++) begin
            tick();
            check({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
            check({tag, " done early"}, 32'(get_done(sel)), 32'd0);
            if (k == 1) begin
                check({tag, " D hold"}, 32'(get_d(sel)), 32'(held_d[sel]));
                check({tag, " Bout hold"}, 32'(get_bo(sel)), 32'(held_bo[sel]));
            end
        end
        tick();
        check({tag, " done"}, 32'(get_done(sel)), 32'd1);
        check({tag, " busy end"}, 32'(get_busy(sel)), 32'd0);
        check({tag, " D"}, 32'(get_d(sel)), 32'(exp_d));
        check({tag, " Bout"}, 32'(get_bo(sel)), 32'(exp_bo));
        held_d[sel]  = 8'(exp_d);
        held_bo[sel] = exp_bo[0];
        tick();
        check({tag, " done pulse"}, 32'(get_done(sel)), 32'd0);
    endtask

    cell_vec_t cell_tab [8];
    op_vec_t   op_tab   [5];

    initial begin
        int ra, rb, ed;

        cell_tab = '{
            '{0,0,0, 0,0}, '{0,0,1, 1,1}, '{0,1,0, 1,1}, '{0,1,1, 0,1},
            '{1,0,0, 1,0}, '{1,0,1, 0,0}, '{1,1,0, 0,0}, '{1,1,1, 1,1}
        };
        op_tab = '{
            '{9, 3, 4'h6, 0},
            '{3, 9, 4'hA, 1},
            '{0, 1, 4'hF, 1},
            '{15, 15, 4'h0, 0},
            '{12, 5, 4'h7, 0}
        };

        rst_n  = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        c_a = 1'b0; c_b = 1'b0; c_bi = 1'b0;
        held_d[0] = '0; held_d[1] = '0;
        held_bo[0] = 1'b0; held_bo[1] = 1'b0;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("reset busy", 32'(busy4), 32'd0);
        check("reset done", 32'(done4), 32'd0);
        check("reset D", 32'(d4), 32'd0);
        check("reset Bout", 32'(bout4), 32'd0);
        check("reset D8", 32'(d8), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Cell truth table
        for (int i = 0; i < 8; i++) begin
            c_a = cell_tab[i].a; c_b = cell_tab[i].b; c_bi = cell_tab[i].bi;
            #1;
            check($sformatf("cell D %0d", i), 32'(c_d), 32'(cell_tab[i].d));
            check($sformatf("cell Bout %0d", i), 32'(c_bo), 32'(cell_tab[i].bo));
        end

        // Directed WIDTH=4 vectors
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, op_tab[i].a, op_tab[i].b, op_tab[i].d, op_tab[i].bo,
                   $sformatf("vec%0d", i));
        end

        // start held high: one done every 6 cycles; A changes mid-flight
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd2;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            check($sformatf("cont done c%0d", cyc), 32'(done4), 32'((cyc % 6) == 0));
            if ((cyc % 6) == 0) begin
                check($sformatf("cont D c%0d", cyc), 32'(d4), (cyc <= 24) ? 32'd3 : 32'd5);
                check($sformatf("cont Bout c%0d", cyc), 32'(bout4), 32'd0);
            end
            if (cyc == 20) a4 = 4'd7;
        end
        start4 = 1'b0;
        held_d[0] = 8'd5; held_bo[0] = 1'b0;
        tick();

        // Reset during the 2nd SHIFT cycle of 12-5
        start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
        tick();
        start4 = 1'b0;
        tick();
        check("mid busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async busy", 32'(busy4), 32'd0);
        check("async done", 32'(done4), 32'd0);
        check("async D", 32'(d4), 32'd0);
        check("async Bout", 32'(bout4), 32'd0);
        held_d[0] = '0; held_bo[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_op(1'b0, 12, 5, 7, 0, "post-reset");

        // WIDTH=8
        run_op(1'b1, 200, 55, 145, 0, "w8 200-55");
        for (int i = 0; i < 500; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            ed = (ra - rb + 256) % 256;
            run_op(1'b1, ra, rb, ed, (ra < rb) ? 1 : 0, $sformatf("rnd%0d %0d-%0d", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
